// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
//   Shared definitions for the two-road intersection controller.
//   - Lamp codes driven onto Alight / Blight.
//   - Controller state codes; these values also appear on the phase output.
//   - dur_ok(): elaboration-time check that a phase duration is usable with a
//     given counter width. The counter holds duration-1, so a duration of
//     exactly 2^CNT_W is still legal.
// -----------------------------------------------------------------------------
package traffic_pkg;

  // Lamp encoding, identical for both roads
  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;
  localparam logic [1:0] OFF    = 2'b11;

  // Controller states. Code 7 is unused and is recovered to RED_BA.
  typedef enum logic [2:0] {
    A_GRN  = 3'd0,
    A_YEL  = 3'd1,
    RED_AB = 3'd2,
    B_GRN  = 3'd3,
    B_YEL  = 3'd4,
    RED_BA = 3'd5,
    FLASH  = 3'd6
  } state_t;

  // True when a duration is at least one cycle and duration-1 fits in cnt_w bits
  function automatic bit dur_ok(input int unsigned dur, input int unsigned cnt_w);
    longint unsigned limit;
    limit = longint'(1) << cnt_w;
    return (dur >= 1) && (longint'(dur) <= limit);
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
//   Loadable down-counter used for every timed interval of the controller,
//   both the phase durations and the flash blink half-period.
//   The count stops at zero instead of wrapping, so a phase that is allowed to
//   rest (main-road green with no demand) simply sits with expired=1.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset, loads RST_VAL
//   load      in   load load_val this cycle (takes priority over counting)
//   load_val  in   value to load, normally duration-1
//   expired   out  counter is zero (last cycle of the current interval)
// -----------------------------------------------------------------------------
module phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl
//   Two-road intersection controller. Road A is the main road and rests in
//   green; road B (side road) is served only on demand. Every change of right
//   of way passes through a yellow and an all-red clearance interval. A
//   pedestrian request forces a side-road service with the walk signal lit
//   for the whole B green. Fail-safe flash (A blinks yellow, B blinks red) is
//   entered and left only through all-red, so a green is never cut short.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   b_req     in   side-road vehicle demand (pre-synchronised)
//   ped_req   in   pedestrian button (pre-synchronised)
//   flash     in   fail-safe flash request (level)
//   Alight    out  road A lamp: 00 green, 01 yellow, 10 red, 11 off
//   Blight    out  road B lamp, same encoding
//   ped_walk  out  walk signal for pedestrians crossing road A
//   phase     out  current state code (debug/status)
//
// Handshake note: b_req and ped_req are plain level/pulse inputs with no
// acknowledge. Any cycle in which one is high is remembered until the side
// road is next served; a request present on the very edge that enters B green
// is treated as served by that green.
// -----------------------------------------------------------------------------
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 3,
  parameter int ALLRED_CYCLES = 2,
  parameter int FLASH_CYCLES  = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b_req,
  input  logic       ped_req,
  input  logic       flash,
  output logic [1:0] Alight,
  output logic [1:0] Blight,
  output logic       ped_walk,
  output logic [2:0] phase
);

  // ---------------------------------------------------------------------------
  // Parameter sanity
  // ---------------------------------------------------------------------------
  if (!dur_ok(GREEN_CYCLES, CNT_W)) begin : g_bad_green
    $error("GREEN_CYCLES must be >= 1 and <= 2**CNT_W");
  end
  if (!dur_ok(YELLOW_CYCLES, CNT_W)) begin : g_bad_yellow
    $error("YELLOW_CYCLES must be >= 1 and <= 2**CNT_W");
  end
  if (!dur_ok(ALLRED_CYCLES, CNT_W)) begin : g_bad_allred
    $error("ALLRED_CYCLES must be >= 1 and <= 2**CNT_W");
  end
  if (!dur_ok(FLASH_CYCLES, CNT_W)) begin : g_bad_flash
    $error("FLASH_CYCLES must be >= 1 and <= 2**CNT_W");
  end

  // Timer load values: an interval of N cycles starts at N-1 and ends at 0
  localparam logic [CNT_W-1:0] G_LD  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] Y_LD  = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] AR_LD = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [CNT_W-1:0] F_LD  = CNT_W'(FLASH_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_t           state_q;
  state_t           state_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_exp;

  logic             b_pend;      // side road owes a service
  logic             ped_pend;    // that service must include a walk
  logic             walk_act;    // walk granted for the current B green
  logic             blink_lit;   // flash half-period: 1 lit, 0 dark
  logic             blink_toggle;
  logic             enter_b_grn;
  logic             enter_flash;

  // ---------------------------------------------------------------------------
  // Shared interval timer
  // ---------------------------------------------------------------------------
  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (G_LD)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= A_GRN;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next state and timer load
  // The timer is reloaded on every phase change; otherwise it counts down and
  // parks at zero, which is how A green rests when nobody is waiting.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_val      = G_LD;
    blink_toggle = 1'b0;
    case (state_q)
      A_GRN: begin
        if (tmr_exp && b_pend) begin
          state_d  = A_YEL;
          tmr_load = 1'b1;
          tmr_val  = Y_LD;
        end
      end
      A_YEL: begin
        if (tmr_exp) begin
          state_d  = RED_AB;
          tmr_load = 1'b1;
          tmr_val  = AR_LD;
        end
      end
      RED_AB: begin
        if (tmr_exp) begin
          tmr_load = 1'b1;
          if (flash) begin
            state_d = FLASH;
            tmr_val = F_LD;
          end else begin
            state_d = B_GRN;
            tmr_val = G_LD;
          end
        end
      end
      B_GRN: begin
        if (tmr_exp) begin
          state_d  = B_YEL;
          tmr_load = 1'b1;
          tmr_val  = Y_LD;
        end
      end
      B_YEL: begin
        if (tmr_exp) begin
          state_d  = RED_BA;
          tmr_load = 1'b1;
          tmr_val  = AR_LD;
        end
      end
      RED_BA: begin
        if (tmr_exp) begin
          tmr_load = 1'b1;
          if (flash) begin
            state_d = FLASH;
            tmr_val = F_LD;
          end else begin
            state_d = A_GRN;
            tmr_val = G_LD;
          end
        end
      end
      FLASH: begin
        // Leaving flash always goes through a full all-red clearance
        if (!flash) begin
          state_d  = RED_BA;
          tmr_load = 1'b1;
          tmr_val  = AR_LD;
        end else if (tmr_exp) begin
          tmr_load     = 1'b1;
          tmr_val      = F_LD;
          blink_toggle = 1'b1;
        end
      end
      default: begin
        // Unused code: recover via all-red toward the main road
        state_d  = RED_BA;
        tmr_load = 1'b1;
        tmr_val  = AR_LD;
      end
    endcase
  end

  assign enter_b_grn = (state_q != B_GRN) && (state_d == B_GRN);
  assign enter_flash = (state_q != FLASH) && (state_d == FLASH);

  // ---------------------------------------------------------------------------
  // Demand latches and blink phase
  // A pedestrian request implies a side-road service. Both latches clear on the
  // edge that starts B green, and the walk grant is captured on that edge so a
  // button press landing exactly then still gets its walk.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      b_pend    <= 1'b0;
      ped_pend  <= 1'b0;
      walk_act  <= 1'b0;
      blink_lit <= 1'b1;
    end else begin
      if (enter_b_grn) begin
        b_pend   <= 1'b0;
        ped_pend <= 1'b0;
        walk_act <= ped_pend | ped_req;
      end else begin
        b_pend   <= b_pend | b_req | ped_req;
        ped_pend <= ped_pend | ped_req;
      end

      // Flash always starts with a lit half-period
      if (enter_flash) begin
        blink_lit <= 1'b1;
      end else if (blink_toggle) begin
        blink_lit <= ~blink_lit;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: Moore output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    Alight   = RED;
    Blight   = RED;
    ped_walk = 1'b0;
    case (state_q)
      A_GRN: begin
        Alight = GREEN;
        Blight = RED;
      end
      A_YEL: begin
        Alight = YELLOW;
        Blight = RED;
      end
      B_GRN: begin
        Alight   = RED;
        Blight   = GREEN;
        ped_walk = walk_act;
      end
      B_YEL: begin
        Alight = RED;
        Blight = YELLOW;
      end
      FLASH: begin
        Alight = blink_lit ? YELLOW : OFF;
        Blight = blink_lit ? RED    : OFF;
      end
      default: begin
        // RED_AB, RED_BA and the unused code show all-red
        Alight = RED;
        Blight = RED;
      end
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_ctrl
//   Directed bench for traffic_light_ctrl with default parameters
//   (green 8, yellow 3, all-red 2, flash half-period 4). Cycle c counts clock
//   periods after the last reset edge; inputs for cycle c are set on the
//   falling edge inside that cycle and outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_traffic_light_ctrl;
  import traffic_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       b_req   = 1'b0;
  logic       ped_req = 1'b0;
  logic       flash   = 1'b0;
  logic [1:0] Alight;
  logic [1:0] Blight;
  logic       ped_walk;
  logic [2:0] phase;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  traffic_light_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .b_req    (b_req),
    .ped_req  (ped_req),
    .flash    (flash),
    .Alight   (Alight),
    .Blight   (Blight),
    .ped_walk (ped_walk),
    .phase    (phase)
  );

  // ---------------------------------------------------------------------------
  // Expected-value helpers (hand timeline: A_GRN 0-7, A_YEL 8-10, RED_AB
  // 11-12, B_GRN 13-20, B_YEL 21-23, RED_BA 24-25, period 26)
  // ---------------------------------------------------------------------------
  function automatic logic [2:0] per_phase(input int c);
    int m;
    m = c % 26;
    if (m < 8)       return 3'd0;
    else if (m < 11) return 3'd1;
    else if (m < 13) return 3'd2;
    else if (m < 21) return 3'd3;
    else if (m < 24) return 3'd4;
    else             return 3'd5;
  endfunction

  function automatic logic [1:0] lamp_a(input logic [2:0] ph);
    case (ph)
      3'd0:    return 2'b00;
      3'd1:    return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] lamp_b(input logic [2:0] ph);
    case (ph)
      3'd3:    return 2'b00;
      3'd4:    return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] ph,
                         input logic [1:0] a, input logic [1:0] b, input logic w);
    chk({tag, ".phase"},    {5'd0, phase},    {5'd0, ph});
    chk({tag, ".Alight"},   {6'd0, Alight},   {6'd0, a});
    chk({tag, ".Blight"},   {6'd0, Blight},   {6'd0, b});
    chk({tag, ".ped_walk"}, {7'd0, ped_walk}, {7'd0, w});
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench on the falling edge of cycle 0 with all inputs low
  task automatic do_reset();
    rst     = 1'b1;
    b_req   = 1'b0;
    ped_req = 1'b0;
    flash   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [2:0] ph;
    logic [1:0] ea;
    logic [1:0] eb;
    logic       ew;

    // Reset state and resting main-road green with no demand
    do_reset();
    chk_all("reset", 3'd0, 2'b00, 2'b10, 1'b0);
    for (int c = 0; c < 40; c++) begin
      chk_all($sformatf("idle_c%0d", c), 3'd0, 2'b00, 2'b10, 1'b0);
      next_cycle();
    end

    // Continuous side-road demand: full 26-cycle cycle, twice
    do_reset();
    b_req = 1'b1;
    for (int c = 0; c <= 52; c++) begin
      ph = per_phase(c);
      chk_all($sformatf("breq_c%0d", c), ph, lamp_a(ph), lamp_b(ph), 1'b0);
      next_cycle();
    end
    b_req = 1'b0;

    // Pedestrian pulses at cycles 3 and 15: two walk services, then rest
    do_reset();
    for (int c = 0; c <= 60; c++) begin
      ped_req = (c == 3) || (c == 15);
      ph = (c < 52) ? per_phase(c) : 3'd0;
      ew = ((c >= 13) && (c <= 20)) || ((c >= 39) && (c <= 46));
      chk_all($sformatf("ped_c%0d", c), ph, lamp_a(ph), lamp_b(ph), ew);
      next_cycle();
    end
    ped_req = 1'b0;

    // Flash requested at cycle 5, honoured at the RED_AB exit (cycle 13),
    // released in cycle 21 -> RED_BA 22-23, A green at 24
    do_reset();
    b_req = 1'b1;
    for (int c = 0; c <= 25; c++) begin
      flash = (c >= 5) && (c <= 20);
      if (c < 13) begin
        ph = per_phase(c);
        ea = lamp_a(ph);
        eb = lamp_b(ph);
      end else if (c <= 21) begin
        ph = 3'd6;
        ea = ((c <= 16) || (c == 21)) ? 2'b01 : 2'b11;
        eb = ((c <= 16) || (c == 21)) ? 2'b10 : 2'b11;
      end else if (c <= 23) begin
        ph = 3'd5;
        ea = 2'b10;
        eb = 2'b10;
      end else begin
        ph = 3'd0;
        ea = 2'b00;
        eb = 2'b10;
      end
      chk_all($sformatf("flash_c%0d", c), ph, ea, eb, 1'b0);
      next_cycle();
    end
    flash = 1'b0;
    b_req = 1'b0;

    // Reset during B_YEL with demand pending: back to green, demand forgotten
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      b_req   = (c < 12);
      ped_req = (c == 15);
      rst     = (c == 22);
      ph = per_phase(c);
      chk_all($sformatf("pre_rst_c%0d", c), ph, lamp_a(ph), lamp_b(ph), 1'b0);
      next_cycle();
    end
    rst     = 1'b0;
    b_req   = 1'b0;
    ped_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      chk_all($sformatf("post_rst_c%0d", c), 3'd0, 2'b00, 2'b10, 1'b0);
      next_cycle();
    end

    // Unused state code 7 recovers through RED_BA
    force dut.state_q = state_t'(3'd7);
    #1;
    chk("illegal.phase", {5'd0, phase}, 8'd7);
    release dut.state_q;
    next_cycle();
    chk_all("illegal_rec1", 3'd5, 2'b10, 2'b10, 1'b0);
    next_cycle();
    chk_all("illegal_rec2", 3'd5, 2'b10, 2'b10, 1'b0);
    next_cycle();
    chk_all("illegal_rec3", 3'd0, 2'b00, 2'b10, 1'b0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Parametrised two-road intersection controller. Road A is the main road and road B is the side road. Adds over the fixed 4-phase controller:
- per-phase programmable durations
- demand-actuated side-road service
- all-red clearance intervals
- pedestrian walk phase
- flashing fail-safe mode
Sits between the intersection sensor and button synchronisers (external) and the lamp drivers.

Parameters:
GREEN_CYCLES, 8, minimum A green and fixed B green length in clk cycles (>=1)
YELLOW_CYCLES, 3, yellow length for either road (>=1)
ALLRED_CYCLES, 2, all-red clearance length (>=1)
FLASH_CYCLES, 4, half-period of flash blink (>=1)
CNT_W, 8, phase counter width; every duration must be <= 2^CNT_W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
b_req  input  1  side-road vehicle demand pulse/level (pre-synchronised)
ped_req  input  1  pedestrian button pulse/level (pre-synchronised)
flash  input  1  fail-safe flash mode request (level)
Alight  output  2  road A lamp: 00 GREEN, 01 YELLOW, 10 RED, 11 OFF
Blight  output  2  road B lamp, same encoding
ped_walk  output  1  walk signal for pedestrians crossing road A
phase  output  3  current state code, for debug/status

Behaviour:
- One clock; reset is synchronous and active-high. rst is sampled only on the rising edge of clk.
- Reset values:
  - state A_GRN; counter = GREEN_CYCLES-1
  - b_pend = 0; ped_pend = 0; walk_act = 0
  - outputs: Alight GREEN, Blight RED, ped_walk 0, phase 0
- Reset mid-phase aborts the phase immediately. No yellow is inserted.
- States and codes: A_GRN 0, A_YEL 1, RED_AB 2, B_GRN 3, B_YEL 4, RED_BA 5, FLASH 6. Code 7 is illegal and goes to RED_BA on the next edge.
- Outputs are Moore-decoded from state and change in the same cycle as state:
  - A_GRN: Alight GREEN, Blight RED
  - A_YEL: Alight YELLOW, Blight RED
  - RED_AB, RED_BA: RED/RED
  - B_GRN: RED/GREEN
  - B_YEL: RED/YELLOW
  - FLASH: Alight alternates YELLOW/OFF and Blight alternates RED/OFF. The first FLASH_CYCLES cycles are lit, then FLASH_CYCLES cycles are OFF, repeating.
  - ped_walk = walk_act while in B_GRN, otherwise 0.
- Timing counter:
  - On phase entry the counter loads duration-1, then decrements each cycle.
  - "expired" means counter == 0.
  - Each timed phase therefore lasts exactly its duration in cycles.
- Demand latches:
  - b_pend is set by b_req=1. ped_pend is set by ped_req=1, and ped_req also sets b_pend.
  - Both latches are cleared on the edge that enters B_GRN. A request asserted on that same edge is consumed, not re-latched.
  - walk_act is loaded with (ped_pend | ped_req) on B_GRN entry.
- Transitions, evaluated on each rising edge with rst=0:
  - A_GRN: expired & b_pend -> A_YEL. If expired and there is no demand, hold A_GRN with the counter held at 0 (rest in main-road green).
  - A_YEL: expired -> RED_AB.
  - RED_AB: expired -> FLASH if flash=1, else B_GRN.
  - B_GRN: expired -> B_YEL. B_GRN is fixed length and not extendable.
  - B_YEL: expired -> RED_BA.
  - RED_BA: expired -> FLASH if flash=1, else A_GRN.
  - FLASH: flash=0 -> RED_BA, with the counter loaded to ALLRED_CYCLES-1. Otherwise stay. The flash counter reloads FLASH_CYCLES-1 on each blink toggle.
- flash is only honoured at all-red exits, so a green phase is never truncated into flash. In flash, b_req and ped_req still latch.
- Counter arithmetic is unsigned CNT_W-bit. Decrement never wraps because the counter is held at 0.

Decomposition:
- Shared package traffic_pkg holds:
  - lamp constants GREEN/YELLOW/RED/OFF
  - state codes
  - a duration-check function (elaboration-time assertion that each duration is >=1 and fits CNT_W)
- One natural sub-module: phase_timer. It is a loadable down-counter with load, load value, and expired outputs, shared by the phase and flash timing.

Test Plan:
- Reset, then b_req held low for 40 cycles -> Alight=00, Blight=10 for all 40 cycles; phase=0; ped_walk=0.
- b_req held high from reset exit (cycle 0) -> expected timeline:
  - A_GRN cycles 0-7
  - A_YEL 8-10
  - RED_AB 11-12
  - B_GRN 13-20
  - B_YEL 21-23
  - RED_BA 24-25
  - A_GRN at cycle 26, with the full period 26 cycles
- One-cycle ped_req at cycle 3 -> ped_walk=1 exactly cycles 13-20. A second ped_req at cycle 15 -> b_pend set; ped_walk=1 again in the next B_GRN only.
- flash=1 asserted at cycle 5 with b_req=1 -> A_GRN and A_YEL complete normally; FLASH entered at cycle 13. Blink pattern: Alight 01,01,01,01 then 11,11,11,11. Deassert flash -> 2 cycles RED/RED, then A_GRN.
- rst pulsed during B_YEL -> next cycle Alight=00, Blight=10, ped_walk=0, and pending demand cleared (no B service without new b_req).
- Force state code 7 via bench backdoor -> RED_BA on the next edge, then A_GRN after 2 cycles.
